// File: rtl/uart_tx_drain_pkg.sv
// Shared types for the queue-draining UART transmitter: byte type, FSM state
// encoding and the even-parity helper used when UART_TX_PARITY_EN is defined.
package uart_tx_drain_pkg;

    typedef logic [7:0] data_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    localparam logic [2:0] LAST_DATA_IDX = 3'd7;

    function automatic logic even_parity(input data_t b);
        return ^b;
    endfunction

endpackage

// File: rtl/uart_tx_drain_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1, restarting on every bit boundary
// or whenever the owner holds clr high.
module baud_counter #(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic bit_done
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_r;
    logic             bit_done_s;

    assign bit_done_s = (cnt_r == LAST);
    assign bit_done   = bit_done_s;

    // Period counter, wraps to zero so the next bit starts cleanly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clr || bit_done_s) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx_drain.sv
// Pops bytes from the upstream queue and sends them as back-to-back UART
// frames (8N1, or 8E1 when UART_TX_PARITY_EN is defined).
module uart_tx_drain
    import uart_tx_drain_pkg::*;
#(
    parameter int CLK_FREQ = 25_000_000,
    parameter int BAUD     = 115_200
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  en,
    input  logic  q_empty,
    input  data_t q_rd_data,
    output logic  q_re,
    output logic  tx,
    output logic  busy
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;

    if (CLKS_PER_BIT < 2) begin : g_bad_baud
        $error("uart_tx_drain: CLKS_PER_BIT must be at least 2");
    end

    uart_state_t state_r;
    uart_state_t state_s;
    data_t       shift_r;
    data_t       shift_s;
    logic [2:0]  idx_r;
    logic [2:0]  idx_s;
    logic        tx_r;
    logic        tx_s;
    logic        busy_r;
    logic        busy_s;
    logic        bit_done_s;
    logic        cnt_clr_s;
    logic        pop_ok_s;
    logic        q_re_s;
`ifdef UART_TX_PARITY_EN
    logic        parity_r;
`endif

    // The counter idles at zero so the start bit gets a full period after a pop.
    assign cnt_clr_s = (state_r == IDLE);

    baud_counter #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .reset    (reset),
        .clr      (cnt_clr_s),
        .bit_done (bit_done_s)
    );

    // Next-state, shifter and pop strobe; a pop only happens at a frame boundary.
    always_comb begin
        state_s  = state_r;
        shift_s  = shift_r;
        idx_s    = idx_r;
        q_re_s   = 1'b0;
        pop_ok_s = !reset && en && !q_empty;
        case (state_r)
            IDLE: begin
                if (pop_ok_s) begin
                    q_re_s  = 1'b1;
                    shift_s = q_rd_data;
                    state_s = START;
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                if (bit_done_s) begin
                    idx_s   = 3'd0;
                    state_s = DATA;
                end else begin
                    state_s = START;
                end
            end
            DATA: begin
                if (bit_done_s) begin
                    shift_s = {1'b0, shift_r[7:1]};
                    idx_s   = idx_r + 3'd1;
                    if (idx_r == LAST_DATA_IDX) begin
`ifdef UART_TX_PARITY_EN
                        state_s = PARITY;
`else
                        state_s = STOP;
`endif
                    end else begin
                        state_s = DATA;
                    end
                end else begin
                    state_s = DATA;
                end
            end
            PARITY: begin
                if (bit_done_s) begin
                    state_s = STOP;
                end else begin
                    state_s = PARITY;
                end
            end
            STOP: begin
                if (bit_done_s) begin
                    if (pop_ok_s) begin
                        q_re_s  = 1'b1;
                        shift_s = q_rd_data;
                        state_s = START;
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    state_s = STOP;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Line level decoded from the state being entered, so tx is registered yet on time.
    always_comb begin
        tx_s   = 1'b1;
        busy_s = 1'b1;
        case (state_s)
            IDLE: begin
                tx_s   = 1'b1;
                busy_s = 1'b0;
            end
            START: begin
                tx_s = 1'b0;
            end
            DATA: begin
                tx_s = shift_s[0];
            end
            PARITY: begin
`ifdef UART_TX_PARITY_EN
                tx_s = parity_r;
`else
                tx_s = 1'b1;
`endif
            end
            STOP: begin
                tx_s = 1'b1;
            end
            default: begin
                tx_s   = 1'b1;
                busy_s = 1'b0;
            end
        endcase
    end

    // Frame state and registered line outputs; reset drops any frame in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            shift_r <= 8'h00;
            idx_r   <= 3'd0;
            tx_r    <= 1'b1;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            shift_r <= shift_s;
            idx_r   <= idx_s;
            tx_r    <= tx_s;
            busy_r  <= busy_s;
        end
    end

`ifdef UART_TX_PARITY_EN
    // Parity is latched from the whole byte at pop time, before shifting destroys it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            parity_r <= 1'b0;
        end else if (q_re_s) begin
            parity_r <= even_parity(q_rd_data);
        end else begin
            parity_r <= parity_r;
        end
    end
`endif

    assign q_re = q_re_s;
    assign tx   = tx_r;
    assign busy = busy_r;

endmodule

// File: tb/tb_uart_tx_drain.sv
// Randomised bench for uart_tx_drain with a queue emulator and a frame-timing
// reference model; honours UART_TX_PARITY_EN for the expected frame layout.
module tb_uart_tx_drain;
    localparam int CPB = 10;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FL = NBITS * CPB;
    localparam int NO_EN_OFF = 1 << 20;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       q_empty;
    logic [7:0] q_rd_data;
    logic       q_re;
    logic       tx;
    logic       busy;

    logic [7:0] bq[$];
    logic [7:0] stim[8];
    int         n_checks = 0;
    int         n_errors = 0;
    logic       tx_o;
    logic       busy_o;
    logic       re_o;

    uart_tx_drain #(
        .CLK_FREQ (1_000_000),
        .BAUD     (100_000)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .q_empty   (q_empty),
        .q_rd_data (q_rd_data),
        .q_re      (q_re),
        .tx        (tx),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic q_sync();
        q_empty   = (bq.size() == 0);
        q_rd_data = (bq.size() == 0) ? 8'h00 : bq[0];
    endtask

    // One clock: sample outputs mid-cycle, then let the queue pop after the edge.
    task automatic step();
        @(negedge clk);
        tx_o   = tx;
        busy_o = busy;
        re_o   = q_re;
        @(posedge clk);
        #1;
        if (re_o && bq.size() > 0) begin
            void'(bq.pop_front());
        end
        q_sync();
    endtask

    // Bit k of the frame for byte b: start, 8 data LSB first, [even parity], stop.
    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
        if (k == 9) return ($countones(b) % 2) == 1;
`endif
        return 1'b1;
    endfunction

    // Queue n bytes from stim, enable, and check every cycle against the model.
    task automatic run_stream(input int n, input int en_off);
        int   nf;
        logic e_re;
        logic e_busy;
        logic e_tx;
        nf = 0;
        for (int k = 0; k < n; k++) begin
            bq.push_back(stim[k]);
            if (k * FL < en_off) nf++;
        end
        q_sync();
        en = 1'b1;
        for (int t = 0; t < nf * FL + 5; t++) begin
            e_re   = (t % FL == 0) && (t / FL < nf);
            e_busy = (t >= 1) && (t <= nf * FL);
            e_tx   = e_busy ? frame_bit(stim[(t - 1) / FL], ((t - 1) % FL) / CPB) : 1'b1;
            step();
            check_val($sformatf("q_re@%0d", t), {31'd0, re_o}, {31'd0, e_re});
            check_val($sformatf("busy@%0d", t), {31'd0, busy_o}, {31'd0, e_busy});
            check_val($sformatf("tx@%0d", t), {31'd0, tx_o}, {31'd0, e_tx});
            if (t + 1 == en_off) en = 1'b0;
        end
        en = 1'b0;
        bq.delete();
        q_sync();
    endtask

    initial begin
        int n;
        int eo;
        reset = 1'b1;
        en    = 1'b0;
        bq.push_back(8'h55);
        q_sync();
        en = 1'b1;
        #1;
        check_val("reset_tx", {31'd0, tx}, 32'd1);
        check_val("reset_busy", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 20; i++) begin
            step();
            check_val("reset_q_re", {31'd0, re_o}, 32'd0);
            check_val("reset_tx_hold", {31'd0, tx_o}, 32'd1);
            check_val("reset_busy_hold", {31'd0, busy_o}, 32'd0);
        end
        en = 1'b0;
        reset = 1'b0;
        bq.delete();
        q_sync();
        step();

        stim[0] = 8'hA5;
        run_stream(1, NO_EN_OFF);
        stim[0] = 8'h00;
        stim[1] = 8'hFF;
        run_stream(2, NO_EN_OFF);

        // Empty queue with en high, then non-empty queue with en low.
        en = 1'b1;
        for (int i = 0; i < 500; i++) begin
            step();
            check_val("empty_q_re", {31'd0, re_o}, 32'd0);
            check_val("empty_tx", {31'd0, tx_o}, 32'd1);
            check_val("empty_busy", {31'd0, busy_o}, 32'd0);
        end
        en = 1'b0;
        bq.push_back(8'h81);
        q_sync();
        for (int i = 0; i < 50; i++) begin
            step();
            check_val("dis_q_re", {31'd0, re_o}, 32'd0);
            check_val("dis_tx", {31'd0, tx_o}, 32'd1);
            check_val("dis_busy", {31'd0, busy_o}, 32'd0);
        end
        bq.delete();
        q_sync();

        // Reset in the middle of a frame, then a clean frame afterwards.
        bq.push_back(8'h5A);
        q_sync();
        en = 1'b1;
        for (int i = 0; i < 46; i++) step();
        reset = 1'b1;
        bq.push_back(8'h99);
        q_sync();
        #1;
        check_val("midrst_tx", {31'd0, tx}, 32'd1);
        check_val("midrst_busy", {31'd0, busy}, 32'd0);
        check_val("midrst_q_re", {31'd0, q_re}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("midrst_q_re_hold", {31'd0, re_o}, 32'd0);
        end
        en = 1'b0;
        bq.delete();
        q_sync();
        reset = 1'b0;
        step();
        stim[0] = 8'h3C;
        run_stream(1, NO_EN_OFF);

        stim[0] = 8'h07;
        stim[1] = 8'h03;
        run_stream(2, NO_EN_OFF);

        // en dropped mid-frame: the current frame completes, no further pops.
        stim[0] = 8'hC3;
        stim[1] = 8'h42;
        run_stream(2, 50);

        for (int r = 0; r < 6; r++) begin
            n  = $urandom_range(1, 3);
            eo = ($urandom_range(0, 1) == 1) ? $urandom_range(1, n * FL) : NO_EN_OFF;
            for (int k = 0; k < n; k++) stim[k] = 8'($urandom);
            run_stream(n, eo);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
